// File: rtl/bram_dp_be_pipe_if.sv
// Write/read/clear bus of the byte-enable dual-port BRAM.
// The requester drives the master side; the memory implements the slave side.
interface bram_dp_be_pipe_if #(
    parameter int ADDRESSWIDTH = 6,
    parameter int BITWIDTH     = 64,
    parameter int LANES        = 8
);
    logic                    wr_en;
    logic [ADDRESSWIDTH-1:0] wr_addr;
    logic [LANES-1:0]        wr_be;
    logic [BITWIDTH-1:0]     wr_data;
    logic                    rd_en;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic [BITWIDTH-1:0]     rd_data;
    logic                    rd_valid;
    logic                    init_req;
    logic                    init_busy;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, init_req,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, init_req,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/bram_dp_be_pipe.sv
// Simple dual-port BRAM: byte-lane write port, 1- or 2-cycle pipelined read port,
// optional same-address write->read bypass and a zeroing clear engine.
module bram_dp_be_pipe #(
    parameter int ADDRESSWIDTH   = 6,
    parameter int DEPTH          = 34,
    parameter int BITWIDTH       = 64,
    parameter int LANES          = 8,
    parameter int RD_LATENCY     = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    bram_dp_be_pipe_if.slave  bus
);

    localparam int LANE_W = BITWIDTH / LANES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESSWIDTH:0] DEPTH_A  = (ADDRESSWIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("bram_dp_be_pipe: RD_LATENCY must be 1 or 2");
        end
        if (BITWIDTH % LANES != 0) begin : g_bad_lanes
            $error("bram_dp_be_pipe: BITWIDTH must be a multiple of LANES");
        end
        if (DEPTH > (2 ** ADDRESSWIDTH)) begin : g_bad_depth
            $error("bram_dp_be_pipe: DEPTH exceeds the address space");
        end
    endgenerate

    // Lane-wise merge: lanes with be=1 come from nw, the rest from old.
    function automatic logic [BITWIDTH-1:0] merge_lanes(
        input logic [BITWIDTH-1:0] old,
        input logic [BITWIDTH-1:0] nw,
        input logic [LANES-1:0]    be
    );
        logic [BITWIDTH-1:0] res;
        res = old;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) res[i*LANE_W +: LANE_W] = nw[i*LANE_W +: LANE_W];
        end
        return res;
    endfunction

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             busy;

    logic [BITWIDTH-1:0] mem [DEPTH];

    logic                wr_in_range, rd_in_range;
    logic                wr_ok, rd_ok;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [BITWIDTH-1:0] rd_old, rd_word;

    assign busy        = (state == CLEAR);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_A);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_A);
    assign wr_ok       = bus.wr_en && !busy && wr_in_range;
    assign rd_ok       = bus.rd_en && !busy;
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_idx      = bus.rd_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // init_req while already clearing is ignored; the sweep is never restarted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.init_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array storage is deliberately not reset; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wr_be[i]) mem[wr_idx][i*LANE_W +: LANE_W] <= bus.wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_old = '0;
        if (rd_in_range) rd_old = mem[rd_idx];
        rd_word = rd_old;
        if (BYPASS != 0 && wr_ok && rd_in_range && (bus.wr_addr == bus.rd_addr)) begin
            rd_word = merge_lanes(rd_old, bus.wr_data, bus.wr_be);
        end
    end

    // Stage p0: array word captured at the accepting edge, so later writes cannot disturb it.
    logic                vld_p0;
    logic [BITWIDTH-1:0] data_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_ok;
            if (rd_ok) data_p0 <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            // Stage p1: extra output register; data only advances with a valid word.
            logic                vld_p1;
            logic [BITWIDTH-1:0] data_p1;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end

            assign bus.rd_valid = vld_p1;
            assign bus.rd_data  = data_p1;
        end else begin : g_lat1
            assign bus.rd_valid = vld_p0;
            assign bus.rd_data  = data_p0;
        end
    endgenerate

    assign bus.init_busy = busy;

endmodule

// File: tb/tb_bram_dp_be_pipe.sv
// Scoreboard bench: two instances (latency 1 with bypass, latency 2 read-first) share
// one stimulus stream and are checked against a word-array reference model.
module tb_bram_dp_be_pipe;

    localparam int AW    = 6;
    localparam int DEPTH = 34;
    localparam int BW    = 64;
    localparam int LN    = 8;

    typedef struct {
        logic [BW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [LN-1:0] wr_be = '0;
    logic [BW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          init_req = 1'b0;

    bram_dp_be_pipe_if #(.ADDRESSWIDTH(AW), .BITWIDTH(BW), .LANES(LN)) a_if ();
    bram_dp_be_pipe_if #(.ADDRESSWIDTH(AW), .BITWIDTH(BW), .LANES(LN)) b_if ();

    assign a_if.wr_en = wr_en;     assign b_if.wr_en = wr_en;
    assign a_if.wr_addr = wr_addr; assign b_if.wr_addr = wr_addr;
    assign a_if.wr_be = wr_be;     assign b_if.wr_be = wr_be;
    assign a_if.wr_data = wr_data; assign b_if.wr_data = wr_data;
    assign a_if.rd_en = rd_en;     assign b_if.rd_en = rd_en;
    assign a_if.rd_addr = rd_addr; assign b_if.rd_addr = rd_addr;
    assign a_if.init_req = init_req; assign b_if.init_req = init_req;

    bram_dp_be_pipe #(.ADDRESSWIDTH(AW), .DEPTH(DEPTH), .BITWIDTH(BW), .LANES(LN),
                      .RD_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if)
    );

    bram_dp_be_pipe #(.ADDRESSWIDTH(AW), .DEPTH(DEPTH), .BITWIDTH(BW), .LANES(LN),
                      .RD_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int clear_left = DEPTH;
    logic [BW-1:0] mdl [DEPTH];
    exp_t qa[$];
    exp_t qb[$];
    logic [BW-1:0] last_a = '0;
    logic [BW-1:0] last_b = '0;

    function automatic logic [BW-1:0] apply_be(input logic [BW-1:0] old, input logic [BW-1:0] nw,
                                               input logic [LN-1:0] be);
        logic [BW-1:0] r;
        r = old;
        for (int i = 0; i < LN; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the memory's rules.
    task automatic model_edge();
        logic [BW-1:0] old, byp;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (rd_en) begin
                old = (int'(rd_addr) < DEPTH) ? mdl[rd_addr] : '0;
                byp = old;
                if (wr_en && wr_addr == rd_addr && int'(rd_addr) < DEPTH) byp = apply_be(old, wr_data, wr_be);
                qa.push_back('{data: byp, due: cyc});
                qb.push_back('{data: old, due: cyc + 1});
            end
            if (wr_en && int'(wr_addr) < DEPTH) mdl[wr_addr] = apply_be(mdl[wr_addr], wr_data, wr_be);
            if (init_req) begin
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
                clear_left = DEPTH;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic op(input logic we, input int wa, input logic [LN-1:0] be, input logic [BW-1:0] wd,
                      input logic re, input int ra, input logic ir);
        wr_en = we; wr_addr = AW'(wa); wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = AW'(ra); init_req = ir;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input logic check_now);
        reset_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; init_req = 1'b0; wr_be = '0;
        qa.delete(); qb.delete();
        last_a = '0; last_b = '0;
        clear_left = DEPTH;
        #1;
        if (check_now) begin
            check("a_rst_valid", {63'd0, a_if.rd_valid}, '0);
            check("a_rst_data", a_if.rd_data, '0);
            check("b_rst_valid", {63'd0, b_if.rd_valid}, '0);
            check("b_rst_data", b_if.rd_data, '0);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Monitors: pop on every rd_valid, otherwise rd_data must hold.
    always @(negedge clk) begin
        exp_t e;
        check("a_busy", {63'd0, a_if.init_busy}, {63'd0, (clear_left > 0)});
        check("b_busy", {63'd0, b_if.init_busy}, {63'd0, (clear_left > 0)});
        if (a_if.rd_valid) begin
            if (qa.size() == 0) check("a_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = qa.pop_front();
                check("a_data", a_if.rd_data, e.data);
                check("a_latency", 64'(cyc), 64'(e.due));
                last_a = e.data;
            end
        end else check("a_hold", a_if.rd_data, last_a);
        if (b_if.rd_valid) begin
            if (qb.size() == 0) check("b_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = qb.pop_front();
                check("b_data", b_if.rd_data, e.data);
                check("b_latency", 64'(cyc), 64'(e.due));
                last_b = e.data;
            end
        end else check("b_hold", b_if.rd_data, last_b);
    end

    initial begin
        int wa, ra;
        #1;
        do_reset(1'b0);
        // Clear after reset, then every word reads zero.
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 0, '0, '0, 1'b1, i, 1'b0);
        idle(3);

        // Lane merge.
        op(1'b1, 5, 8'hFF, 64'h1122334455667788, 1'b0, 0, 1'b0);
        op(1'b1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 0, 1'b0);
        op(1'b0, 0, '0, '0, 1'b1, 5, 1'b0);
        idle(3);

        // Same-cycle collision, then a follow-up read.
        op(1'b1, 7, 8'hFF, 64'h0, 1'b0, 0, 1'b0);
        op(1'b1, 7, 8'hF0, 64'hCAFEBABE00000000, 1'b1, 7, 1'b0);
        op(1'b0, 0, '0, '0, 1'b1, 7, 1'b0);
        idle(3);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) op(1'b1, i, 8'hFF, 64'(8'hA0 + i), 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) op(1'b0, 0, '0, '0, 1'b1, i, 1'b0);
        idle(3);

        // Out-of-range write dropped, out-of-range read returns zero.
        op(1'b1, 6, 8'hFF, 64'h0606060606060606, 1'b0, 0, 1'b0);
        op(1'b1, 8, 8'hFF, 64'h0808080808080808, 1'b0, 0, 1'b0);
        op(1'b1, 40, 8'hFF, 64'hFF, 1'b0, 0, 1'b0);
        op(1'b0, 0, '0, '0, 1'b1, 6, 1'b0);
        op(1'b0, 0, '0, '0, 1'b1, 8, 1'b0);
        op(1'b0, 0, '0, '0, 1'b1, 40, 1'b0);
        idle(3);

        // Fill, clear on request with traffic during the sweep, then read back.
        for (int i = 0; i < DEPTH; i++) op(1'b1, i, 8'hFF, {32'hF00D0000 + i, 32'h1234 + i}, 1'b0, 0, 1'b0);
        op(1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++)
            op(1'b1, i % DEPTH, 8'hFF, 64'hDEAD, 1'b1, (i + 3) % DEPTH, (i == 5));
        for (int i = 0; i < DEPTH; i++) op(1'b0, 0, '0, '0, 1'b1, i, 1'b0);
        idle(3);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 63)) : int'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 (($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 63)) : int'($urandom_range(0, DEPTH - 1)));
            op(1'($urandom_range(0, 1)), wa, LN'($urandom), {$urandom, $urandom},
               1'($urandom_range(0, 1)), ra, ($urandom_range(0, 79) == 0));
        end
        idle(DEPTH + 3);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) op(1'b0, 0, '0, '0, 1'b1, i, 1'b0);
        do_reset(1'b1);
        idle(DEPTH + 2);
        op(1'b0, 0, '0, '0, 1'b1, 2, 1'b0);
        idle(4);

        check("a_queue_empty", 64'(qa.size()), 64'd0);
        check("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
